// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, register map and status layout for mmio_uart_tx
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    localparam logic [31:0] TXDATA_OFS = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;

    localparam int FULL   = 0;
    localparam int EMPTY  = 1;
    localparam int ACTIVE = 2;
    localparam int OVF    = 3;

    // SB, SH and SW are the only store widths the register window answers to
    function automatic logic store_width_ok(input logic [2:0] f);
        return f == 3'b000 || f == 3'b001 || f == 3'b010;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through byte queue with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    assign dout  = mem[rd_ptr_q];

    // a full queue still takes a push when the head leaves in the same cycle
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage needs no reset, occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 transmitter with byte queue and sticky overflow
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int          CLK_FREQ_HZ = 12_000_000,
    parameter int          BAUD        = 115_200,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FFF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write_mem,
    input  logic [2:0]  funct3,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [31:0] read_address,
    output logic [31:0] read_data,
    output logic        tx,
    output logic        busy
);

    localparam int CPB   = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W = $clog2(CPB);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CPB - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             ovf_q, ovf_d;
    logic             wr_tx, wr_st, pop, full, empty;
    logic [7:0]       head;
    logic [CW-1:0]    fifo_count;
    logic [31:0]      status;
    logic             unused_bits;

    assign unused_bits = ^write_data[31:8];

    assign wr_tx = write_mem && store_width_ok(funct3) && write_address == BASE_ADDR + TXDATA_OFS;
    assign wr_st = write_mem && store_width_ok(funct3) && write_address == BASE_ADDR + STATUS_OFS;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_tx),
        .din   (write_data[7:0]),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // serialiser next state: every state or bit change reloads the baud counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q == '0 ? RELOAD : cnt_q - 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                cnt_d = RELOAD;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: if (cnt_q == '0) begin
                state_d = DATA;
                bit_d   = 3'd0;
                tx_d    = shift_q[0];
            end
            DATA: if (cnt_q == '0) begin
                if (bit_q == 3'd7) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    bit_d   = bit_q + 1'b1;
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                end
            end
            STOP: if (cnt_q == '0) begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = START;
                    tx_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // a dropped push sets overflow and beats a simultaneous clear
    always_comb begin
        ovf_d = (wr_tx && full && !pop) || (ovf_q && !(wr_st && write_data[OVF]));
    end

    // serialiser and overflow registers; reset parks the line high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= RELOAD;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    // combinational register read so single-cycle loads complete
    always_comb begin
        status         = '0;
        status[FULL]   = full;
        status[EMPTY]  = empty;
        status[ACTIVE] = state_q != IDLE;
        status[OVF]    = ovf_q;
        read_data      = read_address == BASE_ADDR + STATUS_OFS ? status : '0;
    end

    assign tx   = tx_q;
    assign busy = state_q != IDLE || fifo_count != '0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed and randomized checks of mmio_uart_tx against a frame-level model
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam int          LOG_N = 8192;
    localparam logic [31:0] BASE  = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        write_mem = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] write_address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_address = '0;
    logic [31:0] read_data;
    logic        tx, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic tx_log [LOG_N];
    logic busy_log [LOG_N];
    logic [7:0] bq [$];

    mmio_uart_tx #(
        .CLK_FREQ_HZ (4),
        .BAUD        (1),
        .FIFO_DEPTH  (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .write_mem     (write_mem),
        .funct3        (funct3),
        .write_address (write_address),
        .write_data    (write_data),
        .read_address  (read_address),
        .read_data     (read_data),
        .tx            (tx),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            tx_log[cyc]   <= tx;
            busy_log[cyc] <= busy;
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        @(posedge clk);
        #1;
        write_mem     = 1'b1;
        write_address = a;
        write_data    = d;
        funct3        = f;
    endtask

    task automatic idle_bus();
        @(posedge clk);
        #1;
        write_mem = 1'b0;
    endtask

    task automatic stat(input string tag, input logic [31:0] exp);
        read_address = BASE + 32'd4;
        #1;
        check(tag, 64'(read_data), 64'(exp));
    endtask

    // issue bq as back-to-back stores, then compare the line against ideal 8N1 frames
    task automatic run_burst();
        int k, n, q, s, j, e, waited;
        logic [63:0] obs, exp;
        logic v;
        k = bq.size();
        s = 0;
        for (int i = 0; i < k; i++) begin
            sw(BASE, {24'($urandom), bq[i]}, 3'($urandom_range(0, 2)));
            if (i == 0) s = cyc;
        end
        idle_bus();
        n = k > DEPTH + 1 ? DEPTH + 1 : k;
        q = k == 1 ? 1 : (k - 1 > DEPTH ? DEPTH : k - 1);
        stat("burst_status", {28'd0, k > DEPTH + 1, k >= 2, 1'b0, q == DEPTH});
        write_mem     = 1'b1;
        write_address = BASE + 32'd4;
        write_data    = $urandom | 32'h8;
        funct3        = 3'd2;
        idle_bus();
        stat("ovf_clear", k == 1 ? 32'h6 : {28'd0, 1'b0, 1'b1, 1'b0, q == DEPTH});
        waited = 0;
        while (busy && waited < 400) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("drain_timeout", 64'(waited < 400), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        j = s;
        while (j < s + 10 && tx_log[j] !== 1'b0) j++;
        check("start_latency", 64'(j - s), 64'd2);
        for (int f = 0; f < n; f++) begin
            obs = '0;
            exp = '0;
            for (int c = 0; c < 10 * CPB; c++) begin
                v = c / CPB == 0 ? 1'b0 : (c / CPB == 9 ? 1'b1 : bq[f][c / CPB - 1]);
                exp[c] = v;
                obs[c] = tx_log[j + 10 * CPB * f + c];
            end
            check($sformatf("frame%0d_byte%02h", f, bq[f]), obs, exp);
        end
        e = j + 10 * CPB * n;
        check("busy_last", 64'(busy_log[e - 1]), 64'd1);
        check("busy_drop", 64'(busy_log[e]), 64'd0);
        check("tx_idle_after", 64'(tx_log[e]), 64'd1);
        stat("final_status", 32'h2);
    endtask

    initial begin
        int bad;
        logic [7:0] b;
        read_address = BASE + 32'd4;
        repeat (3) @(posedge clk);
        #1;
        stat("reset_status", 32'h2);
        check("reset_tx", 64'(tx), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        bq = {};
        bq.push_back(8'h55);
        run_burst();

        bq = {};
        for (int i = 1; i <= 6; i++) bq.push_back(8'(i));
        run_burst();

        for (int r = 0; r < 6; r++) begin
            bq = {};
            for (int i = 0; i < int'($urandom_range(1, 7)); i++) bq.push_back(8'($urandom));
            if (bq.size() == 0) bq.push_back(8'($urandom));
            run_burst();
        end

        b = 8'($urandom) & 8'hF7;
        sw(BASE, {24'd0, b}, 3'd2);
        sw(BASE, $urandom, 3'd0);
        idle_bus();
        check("frame_started", 64'(tx), 64'd0);
        repeat (17) @(posedge clk);
        #1;
        check("data_bit3_low", 64'(tx), 64'd0);
        reset = 1'b0;
        #1;
        check("reset_tx_immediate", 64'(tx), 64'd1);
        stat("reset_mid_status", 32'h2);
        check("reset_mid_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("no_frame_after_reset", 64'(bad), 64'd0);
        stat("post_reset_status", 32'h2);

        for (int i = 0; i < 3; i++) sw(BASE, $urandom, 3'($urandom_range(3, 7)));
        sw(BASE + 32'd8, $urandom, 3'd2);
        sw(BASE + 32'd12, $urandom, 3'd0);
        idle_bus();
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("decode_no_push", 64'(bad), 64'd0);
        stat("decode_status", 32'h2);
        read_address = BASE;
        #1;
        check("read_txdata", 64'(read_data), 64'd0);
        read_address = BASE + 32'd8;
        #1;
        check("read_base8", 64'(read_data), 64'd0);
        read_address = {1'b0, 31'($urandom)};
        #1;
        check("read_miss", 64'(read_data), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits directly downstream of the RV32I core's data-memory port, alongside the memory unit. It decodes the core's store/load address bus, queues bytes written to its TXDATA register in a small FIFO, and serialises them on an 8N1 line at a fixed baud rate. Status is readable combinationally so single-cycle loads complete in the same cycle.

## Interface
- CLK_FREQ_HZ, 12_000_000, core clock frequency.
- BAUD, 115_200, line rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD, truncated, must be ≥ 2.
- FIFO_DEPTH, 4, byte entries; must be a power of 2.
- BASE_ADDR, 32'hFFFF_FFF0, word-aligned base of the register window.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- write_mem  input  1  store strobe from the decoder.
- funct3  input  3  store width; 000/001/010 are accepted, all others are ignored.
- write_address  input  32  store address (ALU result).
- write_data  input  32  store data (rs2); only bits [7:0] are used.
- read_address  input  32  load address.
- read_data  output  32  combinational register read; 0 when the address misses.
- tx  output  1  serial line, registered, idle high.
- busy  output  1  high when state ≠ IDLE or the FIFO is not empty.

## Operation
Register map:
- BASE+0 TXDATA:
  - Write pushes write_data[7:0].
  - Read returns 0.
- BASE+4 STATUS:
  - Read fields: bit0 full, bit1 empty, bit2 tx_active, bit3 overflow. Bits [31:4] read 0.
  - Writing 1 to bit3 clears overflow. Other bits are ignored.

Push rules:
- A push is accepted when the FIFO is not full, or when a pop occurs in the same cycle.
- Otherwise the byte is dropped and overflow is set (sticky).
- If a clear and a new overflow occur in the same cycle, the set wins.

FSM states are IDLE, START, DATA, STOP:
- **IDLE:** tx=1. If the FIFO is non-empty: pop into the shift register, enter START, tx=0.
- **START:** hold for CLKS_PER_BIT cycles, then enter DATA with bit index 0.
- **DATA:** drive shift[0] for CLKS_PER_BIT cycles, LSB first. After bit index 7, enter STOP with tx=1.
- **STOP:** hold for CLKS_PER_BIT cycles. At expiry:
  - FIFO non-empty: pop and go directly to START, with no idle gap.
  - FIFO empty: go to IDLE.

Other rules:
- The baud counter reloads to CLKS_PER_BIT-1 on every state or bit change and counts down to 0.
- tx_active = (state ≠ IDLE).

Reset:
- tx=1, busy=0, state IDLE.
- FIFO pointers and count = 0; overflow=0.
- Reset asserted mid-frame forces tx high immediately. The in-flight byte and all queued bytes are discarded.

## Timing
- A store captured at edge E0 into an empty FIFO while IDLE: pop at E1, and tx falls after E1.
- A frame is exactly 10·CLKS_PER_BIT cycles.
- Back-to-back frames have no extra cycles between the end of STOP and the start of START.
- read_data is purely combinational from read_address and current state. STATUS reflects the post-edge state.
- The FIFO count width is $clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - register offsets TXDATA_OFS=0 and STATUS_OFS=4;
  - status bit indices FULL=0, EMPTY=1, ACTIVE=2, OVF=3.
- Sub-module sync_fifo (parameterised WIDTH and DEPTH; push/pop/full/empty/count) holds the byte queue.
- The serialiser FSM, baud counter and address decode live in mmio_uart_tx.

## Test plan
All scenarios use CLK_FREQ_HZ=4 and BAUD=1, so CLKS_PER_BIT=4.
- **Reset:** with reset low, read STATUS → 32'h2; tx=1; busy=0.
- **Single byte:** SW 0x55 to TXDATA → tx pattern: 0 for 4 cycles, then 1,0,1,0,1,0,1,0 for 4 cycles each, then 1 for 4 cycles; busy drops exactly 40 cycles after the first low cycle.
- **Overflow:** 6 SW writes on consecutive cycles (0x01–0x06) → 0x01–0x05 are transmitted contiguously with no gap between frames; 0x06 is dropped; STATUS bit3=1 after the 6th write.
- **Overflow clear:** SW 0x8 to STATUS → STATUS bit3=0; full/empty bits are unchanged.
- **Mid-frame reset:** assert reset during data bit 3 → tx=1 in the same cycle; after release, STATUS=32'h2 and no further frame is sent.
- **Decode:**
  - funct3=100 write to TXDATA → no push.
  - Reading TXDATA or BASE+8 → read_data=0.
  - Store to BASE+8 → no effect.
